// File: rtl/mont_pkg.sv
// Shared types for the Montgomery exponentiation controller: limb type,
// controller state encoding and the Montgomery "one" operand pattern.
package mont_pkg;

    localparam int LIMB_W = 64;

    typedef logic [LIMB_W-1:0] limb_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TO_MONT   = 3'd1,
        ST_SQR       = 3'd2,
        ST_MUL       = 3'd3,
        ST_NEXT      = 3'd4,
        ST_FROM_MONT = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // B operand for leaving the Montgomery domain: limb 0 = 1, all others 0.
    localparam int MONT_ONE_LIMB0 = 1;

    function automatic logic is_issue_state(input state_t s);
        return (s == ST_TO_MONT) || (s == ST_SQR) ||
               (s == ST_MUL) || (s == ST_FROM_MONT);
    endfunction

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a shared montcios
// multiplier through its mont_start/mont_done handshake.
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int S        = 16,
    parameter int EXP_BITS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH*S-1:0]    base,
    input  logic [EXP_BITS-1:0]   exp,
    input  logic [WIDTH*S-1:0]    p,
    input  logic [WIDTH-1:0]      p_prime,
    input  logic [WIDTH*S-1:0]    r2,
    input  logic [WIDTH*S-1:0]    mont_one,
    output logic                  mont_start,
    output logic [WIDTH*S-1:0]    mont_a,
    output logic [WIDTH*S-1:0]    mont_b,
    output logic [WIDTH*S-1:0]    mont_p,
    output logic [WIDTH-1:0]      mont_p_prime,
    input  logic [WIDTH*S-1:0]    mont_result,
    input  logic                  mont_done,
    output logic [WIDTH*S-1:0]    result,
    output logic                  done,
    output logic                  busy
);

    localparam int OPW   = WIDTH * S;
    localparam int IDX_W = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;

    localparam logic [OPW-1:0]   ONE_B   = OPW'(MONT_ONE_LIMB0);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_BITS - 1);

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_mont_start;
    logic [OPW-1:0]       r_mont_a;
    logic [OPW-1:0]       r_mont_b;
    logic [OPW-1:0]       r_mont_p;
    logic [WIDTH-1:0]     r_mont_pp;
    logic [OPW-1:0]       r_acc;
    logic [OPW-1:0]       r_xm;
    logic [OPW-1:0]       r_result;
    logic [EXP_BITS-1:0]  r_exp;
    logic [IDX_W-1:0]     r_idx;

    logic                 w_waiting;
    logic                 w_accept;
    logic                 w_issue;
    logic [OPW-1:0]       w_op_a;
    logic [OPW-1:0]       w_op_b;

    // A done coinciding with our own issue cycle belongs to nobody; only
    // a done strictly after the issue cycle completes the current product.
    assign w_waiting = (r_state == ST_TO_MONT) || (r_state == ST_SQR) ||
                       (r_state == ST_MUL)     || (r_state == ST_FROM_MONT);
    assign w_accept  = w_waiting && mont_done && !r_mont_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_TO_MONT;
                end
            end
            ST_TO_MONT: begin
                if (w_accept) begin
                    w_state_nxt = ST_SQR;
                end
            end
            ST_SQR: begin
                if (w_accept) begin
                    w_state_nxt = r_exp[r_idx] ? ST_MUL : ST_NEXT;
                end
            end
            ST_MUL: begin
                if (w_accept) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                w_state_nxt = (r_idx == '0) ? ST_FROM_MONT : ST_SQR;
            end
            ST_FROM_MONT: begin
                if (w_accept) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operands are chosen by the state being entered so they are already
    // registered in the issue cycle. Entering MUL straight from SQR uses the
    // fresh square on mont_result, since r_acc updates on the same edge.
    always_comb begin
        w_issue = (w_state_nxt != r_state) && is_issue_state(w_state_nxt);
        w_op_a  = r_mont_a;
        w_op_b  = r_mont_b;
        case (w_state_nxt)
            ST_TO_MONT: begin
                w_op_a = base;
                w_op_b = r2;
            end
            ST_SQR: begin
                w_op_a = r_acc;
                w_op_b = r_acc;
            end
            ST_MUL: begin
                w_op_a = mont_result;
                w_op_b = r_xm;
            end
            ST_FROM_MONT: begin
                w_op_a = r_acc;
                w_op_b = ONE_B;
            end
            default: begin
                w_op_a = r_mont_a;
                w_op_b = r_mont_b;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mont_start <= 1'b0;
            r_mont_a     <= '0;
            r_mont_b     <= '0;
            r_mont_p     <= '0;
            r_mont_pp    <= '0;
            r_acc        <= '0;
            r_xm         <= '0;
            r_result     <= '0;
            r_exp        <= '0;
            r_idx        <= '0;
        end else begin
            r_mont_start <= w_issue;
            if (w_issue) begin
                r_mont_a <= w_op_a;
                r_mont_b <= w_op_b;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_exp     <= exp;
                        r_acc     <= mont_one;
                        r_mont_p  <= p;
                        r_mont_pp <= p_prime;
                    end
                end
                ST_TO_MONT: begin
                    if (w_accept) begin
                        r_xm  <= mont_result;
                        r_idx <= IDX_TOP;
                    end
                end
                ST_SQR, ST_MUL: begin
                    if (w_accept) begin
                        r_acc <= mont_result;
                    end
                end
                ST_NEXT: begin
                    if (r_idx != '0) begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                ST_FROM_MONT: begin
                    if (w_accept) begin
                        r_result <= mont_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mont_start   = r_mont_start;
    assign mont_a       = r_mont_a;
    assign mont_b       = r_mont_b;
    assign mont_p       = r_mont_p;
    assign mont_p_prime = r_mont_pp;
    assign result       = r_result;
    assign done         = (r_state == ST_DONE);
    assign busy         = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with p=13 and a behavioural Montgomery
// multiplier whose done latency is random in 3..20 cycles.
module tb_mont_exp_ctrl;

    localparam int WIDTH    = 8;
    localparam int S        = 1;
    localparam int EXP_BITS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_i;
    logic [7:0]  exp_i;
    logic [7:0]  p_i;
    logic [7:0]  pp_i;
    logic [7:0]  r2_i;
    logic [7:0]  one_i;
    logic        mont_start;
    logic [7:0]  mont_a;
    logic [7:0]  mont_b;
    logic [7:0]  mont_p;
    logic [7:0]  mont_p_prime;
    logic [7:0]  mont_result = 8'd0;
    logic        mont_done   = 1'b0;
    logic [7:0]  result;
    logic        done;
    logic        busy;

    int n_checks = 0;
    int n_errs   = 0;
    int n_start  = 0;
    int n_done   = 0;
    bit inject_early = 1'b0;

    always #5 clk = ~clk;

    mont_exp_ctrl #(.WIDTH(WIDTH), .S(S), .EXP_BITS(EXP_BITS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base(base_i), .exp(exp_i), .p(p_i), .p_prime(pp_i),
        .r2(r2_i), .mont_one(one_i),
        .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b),
        .mont_p(mont_p), .mont_p_prime(mont_p_prime),
        .mont_result(mont_result), .mont_done(mont_done),
        .result(result), .done(done), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, want);
        end
    endtask

    // Montgomery product for p=13, R=256: a*b*R^-1 mod 13, with R^-1 = 3.
    logic [7:0] m_a, m_b, m_res;
    int         m_cnt = 0;

    always @(negedge clk) begin
        mont_done = 1'b0;
        if (m_cnt > 0) begin
            if (busy && !rst) begin
                chk("hold_a", 32'(mont_a), 32'(m_a));
                chk("hold_b", 32'(mont_b), 32'(m_b));
            end
            m_cnt--;
            if (m_cnt == 0) begin
                mont_done   = 1'b1;
                mont_result = m_res;
            end
        end
        if (mont_start) begin
            n_start++;
            m_a   = mont_a;
            m_b   = mont_b;
            m_res = 8'((int'(mont_a) * int'(mont_b) * 3) % 13);
            m_cnt = $urandom_range(20, 3);
            chk("mont_p", 32'(mont_p), 32'd13);
            chk("mont_pp", 32'(mont_p_prime), 32'd59);
            if (inject_early) begin
                mont_done   = 1'b1;
                mont_result = 8'hAA;
            end
        end
        if (done) n_done++;
    end

    task automatic launch(input logic [7:0] b, input logic [7:0] e);
        @(negedge clk);
        base_i = b;
        exp_i  = e;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        #1;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic finish_job(input string tag, input int s0, input int d0,
                              input logic [7:0] want_res, input int want_starts);
        int cyc;
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_timeout"}, 32'(cyc < 5000), 32'd1);
        chk({tag, "_result"}, 32'(result), 32'(want_res));
        chk({tag, "_starts"}, 32'(n_start - s0), 32'(want_starts));
        @(negedge clk);
        #1;
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_done_cnt"}, 32'(n_done - d0), 32'd1);
        chk({tag, "_result_hold"}, 32'(result), 32'(want_res));
    endtask

    task automatic run_job(input string tag, input logic [7:0] b, input logic [7:0] e,
                           input logic [7:0] want_res, input int want_starts);
        int s0, d0;
        s0 = n_start;
        d0 = n_done;
        launch(b, e);
        finish_job(tag, s0, d0, want_res, want_starts);
    endtask

    initial begin
        int s0, d0, cyc;
        rst    = 1'b1;
        start  = 1'b0;
        base_i = 8'd0;
        exp_i  = 8'd0;
        p_i    = 8'd13;
        pp_i   = 8'd59;
        r2_i   = 8'd3;
        one_i  = 8'd9;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mont_start", 32'(mont_start), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_mont_a", 32'(mont_a), 32'd0);
        chk("rst_mont_b", 32'(mont_b), 32'd0);
        chk("rst_mont_p", 32'(mont_p), 32'd0);
        chk("rst_mont_pp", 32'(mont_p_prime), 32'd0);
        rst = 1'b0;

        run_job("s1_2pow10", 8'd2, 8'd10, 8'd10, 12);
        run_job("s2_2pow255", 8'd2, 8'd255, 8'd8, 18);
        run_job("s3_exp0", 8'd7, 8'd0, 8'd1, 10);
        run_job("s3_base0", 8'd0, 8'd5, 8'd0, 12);

        // Second start while busy, carrying different operands, must be dropped.
        s0 = n_start;
        d0 = n_done;
        launch(8'd12, 8'd2);
        repeat (4) @(negedge clk);
        base_i = 8'd2;
        exp_i  = 8'd10;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        finish_job("s4_12pow2", s0, d0, 8'd1, 11);

        // Reset while the first MUL (7th product) of 2^10 is outstanding.
        s0 = n_start;
        d0 = n_done;
        launch(8'd2, 8'd10);
        cyc = 0;
        while ((n_start - s0) < 7 && cyc < 5000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("s5_reach_mul", 32'(cyc < 5000), 32'd1);
        rst = 1'b1;
        #1;
        chk("s5_rst_busy", 32'(busy), 32'd0);
        chk("s5_rst_mont_start", 32'(mont_start), 32'd0);
        chk("s5_rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk("s5_late_done_busy", 32'(busy), 32'd0);
        chk("s5_late_done_nodone", 32'(n_done - d0), 32'd0);
        chk("s5_late_done_result", 32'(result), 32'd0);
        run_job("s5_fresh", 8'd2, 8'd10, 8'd10, 12);

        // Spurious done raised alongside every issue pulse must not advance.
        inject_early = 1'b1;
        run_job("s6_early_done", 8'd2, 8'd10, 8'd10, 12);
        inject_early = 1'b0;
        repeat (25) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
